// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall requests into per-stage holds, sequences
// exception/bus-timeout redirects with flush, and keeps stall/flush counters.
module pipe_ctrl #(
  parameter int unsigned STALL_TIMEOUT = 255,
  parameter logic [31:0] TIMEOUT_VEC   = 32'h0000_0180,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             new_pc_valid,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(STALL_TIMEOUT + 1);
  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(STALL_TIMEOUT - 1);
  localparam logic [FL_W-1:0] FL_INIT = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [FL_W-1:0]   flush_left_q, flush_left_d;
  logic              flush_q, flush_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic              npv_q, npv_d;
  logic              bto_q, bto_d;
  logic [CNT_W-1:0]  sc_q, sc_d;
  logic [CNT_W-1:0]  fc_q, fc_d;
  logic              redir;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    flush_left_d = flush_left_q;
    flush_d      = flush_q;
    new_pc_d     = new_pc_q;
    npv_d        = npv_q;
    bto_d        = 1'b0;
    sc_d         = sc_q;
    fc_d         = fc_q;
    stall        = 6'b000000;
    redir        = 1'b0;

    unique case (state_q)
      RUN: begin
        // Gate on rst so holds drop while reset is asserted.
        if (rst) begin
          if (stallreq_mem)     stall = 6'b011111;
          else if (stallreq_ex) stall = 6'b001111;
          else if (stallreq_id) stall = 6'b000111;
          else                  stall = 6'b000000;
        end

        if (stallreq_mem) wait_cnt_d = wait_cnt_q + WC_W'(1);
        else              wait_cnt_d = '0;

        if (excp_valid) begin
          redir    = 1'b1;
          new_pc_d = excp_pc;
        end else if (stallreq_mem && wait_cnt_q == WC_LAST) begin
          redir    = 1'b1;
          new_pc_d = TIMEOUT_VEC;
          bto_d    = 1'b1;
        end

        if (redir) begin
          state_d      = FLUSH;
          flush_d      = 1'b1;
          npv_d        = 1'b1;
          flush_left_d = FL_INIT;
          wait_cnt_d   = '0;
          if (fc_q != '1) fc_d = fc_q + CNT_W'(1);
        end
      end
      FLUSH: begin
        wait_cnt_d = '0;
        if (flush_left_q == '0) begin
          flush_d = 1'b0;
          npv_d   = 1'b0;
          state_d = RUN;
        end else begin
          flush_left_d = flush_left_q - FL_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (stall != 6'b000000 && sc_q != '1) sc_d = sc_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      wait_cnt_q   <= '0;
      flush_left_q <= '0;
      flush_q      <= 1'b0;
      new_pc_q     <= '0;
      npv_q        <= 1'b0;
      bto_q        <= 1'b0;
      sc_q         <= '0;
      fc_q         <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      flush_left_q <= flush_left_d;
      flush_q      <= flush_d;
      new_pc_q     <= new_pc_d;
      npv_q        <= npv_d;
      bto_q        <= bto_d;
      sc_q         <= sc_d;
      fc_q         <= fc_d;
    end
  end

  assign flush        = flush_q;
  assign new_pc       = new_pc_q;
  assign new_pc_valid = npv_q;
  assign bus_timeout  = bto_q;
  assign stall_cycles = sc_q;
  assign flush_count  = fc_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: two instances (short/long flush) against
// a cycle-count reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        excp_valid = 1'b0;
  logic [31:0] excp_pc = '0;

  logic [5:0]  o_stall [2];
  logic        o_flush [2];
  logic [31:0] o_pc    [2];
  logic        o_npv   [2];
  logic        o_bto   [2];
  logic [3:0]  a_sc, a_fc;
  logic [7:0]  b_sc, b_fc;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .STALL_TIMEOUT(4), .TIMEOUT_VEC(32'h0000_0180),
    .FLUSH_CYCLES(1), .CNT_W(4)
  ) u_a (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .stall(o_stall[0]), .flush(o_flush[0]),
    .new_pc(o_pc[0]), .new_pc_valid(o_npv[0]),
    .bus_timeout(o_bto[0]),
    .stall_cycles(a_sc), .flush_count(a_fc)
  );

  pipe_ctrl #(
    .STALL_TIMEOUT(4), .TIMEOUT_VEC(32'h0000_0180),
    .FLUSH_CYCLES(3), .CNT_W(8)
  ) u_b (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excp_valid(excp_valid), .excp_pc(excp_pc),
    .stall(o_stall[1]), .flush(o_flush[1]),
    .new_pc(o_pc[1]), .new_pc_valid(o_npv[1]),
    .bus_timeout(o_bto[1]),
    .stall_cycles(b_sc), .flush_count(b_fc)
  );

  // reference model state, one slot per instance
  int          p_fc [2] = '{1, 3};
  int          p_cw [2] = '{4, 8};
  int          m_rem [2];
  int          m_run [2];
  bit          m_bto [2];
  logic [31:0] m_pc  [2];
  longint      m_sc  [2];
  longint      m_fc  [2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint sat_inc(longint v, int cw);
    longint mx = (longint'(1) << cw) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  function automatic logic [5:0] exp_stall(int i);
    if (!rst || m_rem[i] > 0) return 6'd0;
    if (stallreq_mem) return 6'b011111;
    if (stallreq_ex)  return 6'b001111;
    if (stallreq_id)  return 6'b000111;
    return 6'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_rem[i] = 0; m_run[i] = 0; m_bto[i] = 0;
      m_pc[i] = '0; m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  // m_rem = number of flush cycles still to be shown (0 = running)
  task automatic model_step(int i);
    bit go = 0;
    m_bto[i] = 0;
    if (m_rem[i] > 0) begin
      m_rem[i]--;
    end else begin
      if (exp_stall(i) != 0) m_sc[i] = sat_inc(m_sc[i], p_cw[i]);
      if (excp_valid) begin
        go = 1; m_pc[i] = excp_pc;
      end else if (stallreq_mem && m_run[i] + 1 == 4) begin
        go = 1; m_pc[i] = 32'h180; m_bto[i] = 1;
      end
      m_run[i] = stallreq_mem ? m_run[i] + 1 : 0;
      if (go) begin
        m_run[i] = 0;
        m_rem[i] = p_fc[i];
        m_fc[i]  = sat_inc(m_fc[i], p_cw[i]);
      end
    end
  endtask

  task automatic check_regs();
    logic [7:0] sc [2];
    logic [7:0] fc [2];
    sc[0] = {4'd0, a_sc}; sc[1] = b_sc;
    fc[0] = {4'd0, a_fc}; fc[1] = b_fc;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("flush%0d", i), 64'(o_flush[i]), 64'(m_rem[i] > 0));
      chk($sformatf("npv%0d", i), 64'(o_npv[i]), 64'(m_rem[i] > 0));
      chk($sformatf("new_pc%0d", i), 64'(o_pc[i]), 64'(m_pc[i]));
      chk($sformatf("bus_to%0d", i), 64'(o_bto[i]), 64'(m_bto[i]));
      chk($sformatf("stall_cyc%0d", i), 64'(sc[i]), 64'(m_sc[i]));
      chk($sformatf("flush_cnt%0d", i), 64'(fc[i]), 64'(m_fc[i]));
    end
  endtask

  task automatic step(bit id, bit ex, bit mem, bit ev, logic [31:0] pc);
    stallreq_id  = id;
    stallreq_ex  = ex;
    stallreq_mem = mem;
    excp_valid   = ev;
    excp_pc      = pc;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("stall%0d", i), 64'(o_stall[i]), 64'(exp_stall(i)));
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    // reset with every request asserted
    stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1;
    excp_valid = 1; excp_pc = 32'hdead_beef;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_regs();
      for (int i = 0; i < 2; i++)
        chk("rst_stall", 64'(o_stall[i]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // stall priority
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("prio_sc", 64'(b_sc), 64'd3);

    // exception redirect
    step(0, 0, 0, 1, 32'h200);
    chk("excp_pc", 64'(o_pc[0]), 64'h200);
    step(0, 0, 0, 0, 0);
    chk("excp_done", 64'(o_flush[0]), 64'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // 3-cycle stall then ready, then full timeout
    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    chk("to_pulse", 64'(o_bto[0]), 64'd1);
    chk("to_pc", 64'(o_pc[0]), 64'h180);
    repeat (4) step(0, 0, 0, 0, 0);

    // exception on the timeout edge, then a second one during flush
    repeat (3) step(0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 32'h300);
    chk("coll_bto", 64'(o_bto[1]), 64'd0);
    chk("coll_pc", 64'(o_pc[1]), 64'h300);
    step(0, 0, 0, 1, 32'h400);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("ign_pc", 64'(o_pc[1]), 64'h300);

    // counter saturation
    do_reset();
    repeat (20) step(1, 0, 0, 0, 0);
    chk("sat_sc", 64'(a_sc), 64'd15);

    // async reset in the middle of a flush
    step(0, 0, 0, 1, 32'h244);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_regs();
    @(negedge clk);
    rst = 1'b1;

    // random traffic
    for (int c = 0; c < 600; c++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0,
           $urandom & 32'hffff_fffc);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
